// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Two-port arbiter for an asynchronous 16-bit SRAM.  A VGA scanout read port
// and a draw read/write port share the SRAM; every access takes two cycles
// and back-to-back accesses issue with no idle cycle between them.
//
// Optional feature (macro SRAM_ARB_FAIR_EN): VGA normally has strict
// priority.  With the macro defined, after FAIR_MAX consecutive VGA grants
// while drw_req stays pending, the draw port wins the next decision.
//
// Ports
//   Clk, Reset                 clock, synchronous active-high reset
//   vga_req/vga_addr           scanout read request, held until vga_gnt
//   vga_gnt                    combinational accept pulse
//   vga_rdata/vga_rvalid       read data, valid for one cycle (gnt + 3)
//   drw_req/we/addr/wdata/be   draw request; be[1] = upper byte
//   drw_gnt                    combinational accept pulse
//   drw_ack/drw_rdata          completion pulse (gnt + 3), rdata on reads
//   SRAM_*                     SRAM pins, controls active-low
//
// State table
//   IDLE | no access in flight; decision point
//   RD_A | read, first cycle (CE_N/OE_N low)
//   RD_B | read, second cycle; DQ captured at its end; decision point
//   WR_A | write strobe cycle (WE_N low, DQ driven)
//   WR_B | write data hold (WE_N high, DQ driven); decision point
// ---------------------------------------------------------------------------
module sram_arbiter #(
   parameter int FAIR_MAX = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        vga_req,
   input  logic [19:0] vga_addr,
   output logic        vga_gnt,
   output logic [15:0] vga_rdata,
   output logic        vga_rvalid,
   input  logic        drw_req,
   input  logic        drw_we,
   input  logic [19:0] drw_addr,
   input  logic [15:0] drw_wdata,
   input  logic [1:0]  drw_be,
   output logic        drw_gnt,
   output logic        drw_ack,
   output logic [15:0] drw_rdata,
   inout  wire  [15:0] SRAM_DQ,
   output logic [19:0] SRAM_ADDR,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B} state_t;

   state_t      state_q, state_d;
   logic        own_drw_q;
   logic [15:0] wdata_q;
   logic        dq_oe_q;
   logic [19:0] addr_q;
   logic        ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;
   logic [15:0] vga_rdata_q, drw_rdata_q;
   logic        vga_rvalid_q, drw_ack_q;

   logic        decide;
   logic        fair_force;
   logic [1:0]  lanes_d;

   assign decide  = (state_q == IDLE) || (state_q == RD_B) || (state_q == WR_B);
   assign vga_gnt = !Reset && decide && vga_req && !fair_force;
   assign drw_gnt = !Reset && decide && drw_req && (!vga_req || fair_force);

   // Byte lanes for the access being accepted this cycle (VGA reads both).
   assign lanes_d = vga_gnt ? 2'b11 : drw_be;

`ifdef SRAM_ARB_FAIR_EN
   localparam int CW = (FAIR_MAX < 1) ? 1 : $clog2(FAIR_MAX + 1);
   logic [CW-1:0] fair_cnt_q;

   assign fair_force = drw_req && (fair_cnt_q == CW'(FAIR_MAX));

   // vga_gnt already excludes fair_force, so the count never passes FAIR_MAX.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         fair_cnt_q <= '0;
      end else if (drw_gnt || !drw_req) begin
         fair_cnt_q <= '0;
      end else if (vga_gnt) begin
         fair_cnt_q <= fair_cnt_q + CW'(1);
      end
   end
`else
   logic fair_unused;
   assign fair_unused = (FAIR_MAX > 0);
   assign fair_force  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         RD_A:    state_d = RD_B;
         WR_A:    state_d = WR_B;
         default: begin
            if (vga_gnt)      state_d = RD_A;
            else if (drw_gnt) state_d = drw_we ? WR_A : RD_A;
            else              state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         own_drw_q    <= 1'b0;
         wdata_q      <= '0;
         dq_oe_q      <= 1'b0;
         addr_q       <= '0;
         ce_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         ub_n_q       <= 1'b1;
         lb_n_q       <= 1'b1;
         vga_rdata_q  <= '0;
         drw_rdata_q  <= '0;
         vga_rvalid_q <= 1'b0;
         drw_ack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         vga_rvalid_q <= (state_q == RD_B) && !own_drw_q;
         drw_ack_q    <= ((state_q == RD_B) && own_drw_q) || (state_q == WR_B);

         if (state_q == RD_B) begin
            if (own_drw_q) drw_rdata_q <= SRAM_DQ;
            else           vga_rdata_q <= SRAM_DQ;
         end

         if (vga_gnt) begin
            own_drw_q <= 1'b0;
            addr_q    <= vga_addr;
         end else if (drw_gnt) begin
            own_drw_q <= 1'b1;
            addr_q    <= drw_addr;
            wdata_q   <= drw_wdata;
         end

         // Pin controls are registered from the next state so they change
         // on the same edge as the state.  RD_B holds the RD_A pins.
         case (state_d)
            RD_A: begin
               ce_n_q  <= 1'b0;
               oe_n_q  <= 1'b0;
               we_n_q  <= 1'b1;
               ub_n_q  <= ~lanes_d[1];
               lb_n_q  <= ~lanes_d[0];
               dq_oe_q <= 1'b0;
            end
            WR_A: begin
               ce_n_q  <= 1'b0;
               oe_n_q  <= 1'b1;
               we_n_q  <= 1'b0;
               ub_n_q  <= ~lanes_d[1];
               lb_n_q  <= ~lanes_d[0];
               dq_oe_q <= 1'b1;
            end
            WR_B: begin
               we_n_q <= 1'b1;
            end
            RD_B: begin
            end
            default: begin
               ce_n_q  <= 1'b1;
               oe_n_q  <= 1'b1;
               we_n_q  <= 1'b1;
               ub_n_q  <= 1'b1;
               lb_n_q  <= 1'b1;
               dq_oe_q <= 1'b0;
            end
         endcase
      end
   end

   assign SRAM_DQ    = dq_oe_q ? wdata_q : 16'bz;
   assign SRAM_ADDR  = addr_q;
   assign SRAM_CE_N  = ce_n_q;
   assign SRAM_OE_N  = oe_n_q;
   assign SRAM_WE_N  = we_n_q;
   assign SRAM_UB_N  = ub_n_q;
   assign SRAM_LB_N  = lb_n_q;
   assign vga_rdata  = vga_rdata_q;
   assign vga_rvalid = vga_rvalid_q;
   assign drw_rdata  = drw_rdata_q;
   assign drw_ack    = drw_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        vga_req = 1'b0;
   logic [19:0] vga_addr = '0;
   logic        vga_gnt;
   logic [15:0] vga_rdata;
   logic        vga_rvalid;
   logic        drw_req = 1'b0;
   logic        drw_we = 1'b0;
   logic [19:0] drw_addr = '0;
   logic [15:0] drw_wdata = '0;
   logic [1:0]  drw_be = '0;
   logic        drw_gnt;
   logic        drw_ack;
   logic [15:0] drw_rdata;
   wire  [15:0] SRAM_DQ;
   logic [19:0] SRAM_ADDR;
   logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

   int checks = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   sram_arbiter #(.FAIR_MAX(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
      .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
      .drw_req(drw_req), .drw_we(drw_we), .drw_addr(drw_addr),
      .drw_wdata(drw_wdata), .drw_be(drw_be), .drw_gnt(drw_gnt),
      .drw_ack(drw_ack), .drw_rdata(drw_rdata),
      .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N),
      .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
      .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
   );

   // SRAM model: 4K words indexed by low address bits; probe_en drives 0
   // onto DQ so a released bus reads back as exactly 0.
   logic [15:0] mem [0:4095];
   logic        pre_we = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [15:0] pre_data = '0;
   logic        probe_en = 1'b0;
   logic        tb_drv;

   assign tb_drv  = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) || probe_en;
   assign SRAM_DQ = tb_drv ? (probe_en ? 16'h0000 : mem[SRAM_ADDR[11:0]]) : 16'hzzzz;

   always @(posedge Clk) begin
      if (pre_we) begin
         mem[pre_addr] <= pre_data;
      end else if (!SRAM_CE_N && !SRAM_WE_N) begin
         if (!SRAM_UB_N) mem[SRAM_ADDR[11:0]][15:8] <= SRAM_DQ[15:8];
         if (!SRAM_LB_N) mem[SRAM_ADDR[11:0]][7:0]  <= SRAM_DQ[7:0];
      end
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic smp();
      @(negedge Clk);
   endtask

   task automatic preload(input logic [11:0] a, input logic [15:0] d);
      cyc();
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      cyc();
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; vga_req = 1'b1; drw_req = 1'b1; probe_en = 1'b1;
      cyc(); cyc(); smp();
      checks++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b11111) begin failures++; $display("FAIL reset_ctrl got=%b exp=11111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}); end
      checks++; if (SRAM_ADDR !== 20'h0) begin failures++; $display("FAIL reset_addr got=%h exp=00000", SRAM_ADDR); end
      checks++; if ({vga_gnt, drw_gnt, vga_rvalid, drw_ack} !== 4'b0000) begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {vga_gnt, drw_gnt, vga_rvalid, drw_ack}); end
      checks++; if ({vga_rdata, drw_rdata} !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", {vga_rdata, drw_rdata}); end
      checks++; if (SRAM_DQ !== 16'h0000) begin failures++; $display("FAIL reset_dq_released got=%h exp=0000", SRAM_DQ); end
      cyc();
      Reset = 1'b0; vga_req = 1'b0; drw_req = 1'b0; probe_en = 1'b0;
      cyc();
   endtask

   task automatic test_vga_read();
      preload(12'h100, 16'hBEEF);
      cyc(); vga_req = 1'b1; vga_addr = 20'h00100; smp();
      checks++; if ({vga_gnt, drw_gnt} !== 2'b10) begin failures++; $display("FAIL vga_grant got=%b exp=10", {vga_gnt, drw_gnt}); end
      cyc(); vga_req = 1'b0; smp();
      checks++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b00100) begin failures++; $display("FAIL vga_rd_a_ctrl got=%b exp=00100", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}); end
      checks++; if (SRAM_ADDR !== 20'h00100) begin failures++; $display("FAIL vga_rd_addr got=%h exp=00100", SRAM_ADDR); end
      cyc(); smp();
      checks++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, vga_rvalid} !== 4'b0010) begin failures++; $display("FAIL vga_rd_b_ctrl got=%b exp=0010", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, vga_rvalid}); end
      cyc(); smp();
      checks++; if ({vga_rvalid, vga_rdata} !== {1'b1, 16'hBEEF}) begin failures++; $display("FAIL vga_rdata got=%b/%h exp=1/beef", vga_rvalid, vga_rdata); end
      cyc(); smp();
      checks++; if ({vga_rvalid, vga_rdata} !== {1'b0, 16'hBEEF}) begin failures++; $display("FAIL vga_rdata_hold got=%b/%h exp=0/beef", vga_rvalid, vga_rdata); end
      checks++; if ({SRAM_CE_N, SRAM_ADDR} !== {1'b1, 20'h00100}) begin failures++; $display("FAIL idle_addr_hold got=%b/%h exp=1/00100", SRAM_CE_N, SRAM_ADDR); end
   endtask

   task automatic test_draw_write();
      int we_low;
      we_low = 0;
      preload(12'h345, 16'h1234);
      cyc(); drw_req = 1'b1; drw_we = 1'b1; drw_addr = 20'h12345; drw_wdata = 16'hA55A; drw_be = 2'b10; smp();
      checks++; if ({vga_gnt, drw_gnt} !== 2'b01) begin failures++; $display("FAIL drw_grant got=%b exp=01", {vga_gnt, drw_gnt}); end
      if (!SRAM_WE_N) we_low++;
      cyc(); drw_req = 1'b0; smp();
      if (!SRAM_WE_N) we_low++;
      checks++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b01001) begin failures++; $display("FAIL wr_a_ctrl got=%b exp=01001", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}); end
      checks++; if ({SRAM_ADDR, SRAM_DQ} !== {20'h12345, 16'hA55A}) begin failures++; $display("FAIL wr_a_bus got=%h/%h exp=12345/a55a", SRAM_ADDR, SRAM_DQ); end
      cyc(); smp();
      if (!SRAM_WE_N) we_low++;
      checks++; if ({SRAM_WE_N, SRAM_DQ, drw_ack} !== {1'b1, 16'hA55A, 1'b0}) begin failures++; $display("FAIL wr_b_hold got=%b/%h/%b exp=1/a55a/0", SRAM_WE_N, SRAM_DQ, drw_ack); end
      cyc(); smp();
      if (!SRAM_WE_N) we_low++;
      checks++; if ({drw_ack, SRAM_CE_N} !== 2'b11) begin failures++; $display("FAIL wr_ack got=%b exp=11", {drw_ack, SRAM_CE_N}); end
      checks++; if (we_low !== 1) begin failures++; $display("FAIL wr_we_pulse got=%0d exp=1", we_low); end
      checks++; if (mem[12'h345] !== 16'hA534) begin failures++; $display("FAIL wr_mem_upper got=%h exp=a534", mem[12'h345]); end
   endtask

   task automatic test_be_zero();
      cyc(); drw_req = 1'b1; drw_we = 1'b1; drw_addr = 20'h00345; drw_wdata = 16'hFFFF; drw_be = 2'b00; smp();
      checks++; if (drw_gnt !== 1'b1) begin failures++; $display("FAIL be0_grant got=%b exp=1", drw_gnt); end
      cyc(); drw_req = 1'b0; smp();
      checks++; if ({SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 3'b011) begin failures++; $display("FAIL be0_lanes got=%b exp=011", {SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}); end
      cyc(); smp(); cyc(); smp();
      checks++; if (drw_ack !== 1'b1) begin failures++; $display("FAIL be0_ack got=%b exp=1", drw_ack); end
      checks++; if (mem[12'h345] !== 16'hA534) begin failures++; $display("FAIL be0_mem got=%h exp=a534", mem[12'h345]); end
   endtask

   task automatic test_simultaneous();
      cyc(); vga_req = 1'b1; vga_addr = 20'h00100;
      drw_req = 1'b1; drw_we = 1'b0; drw_addr = 20'h00345; drw_be = 2'b11; smp();
      checks++; if ({vga_gnt, drw_gnt} !== 2'b10) begin failures++; $display("FAIL sim_first got=%b exp=10", {vga_gnt, drw_gnt}); end
      cyc(); vga_req = 1'b0; smp();
      checks++; if ({drw_gnt, SRAM_CE_N} !== 2'b00) begin failures++; $display("FAIL sim_rd_a got=%b exp=00", {drw_gnt, SRAM_CE_N}); end
      cyc(); smp();
      checks++; if ({drw_gnt, SRAM_CE_N} !== 2'b10) begin failures++; $display("FAIL sim_second got=%b exp=10", {drw_gnt, SRAM_CE_N}); end
      cyc(); drw_req = 1'b0; smp();
      checks++; if ({vga_rvalid, vga_rdata, SRAM_CE_N, SRAM_ADDR} !== {1'b1, 16'hBEEF, 1'b0, 20'h00345}) begin failures++; $display("FAIL sim_no_idle got=%b/%h/%b/%h exp=1/beef/0/00345", vga_rvalid, vga_rdata, SRAM_CE_N, SRAM_ADDR); end
      cyc(); smp();
      checks++; if ({SRAM_CE_N, drw_ack} !== 2'b00) begin failures++; $display("FAIL sim_rd_b got=%b exp=00", {SRAM_CE_N, drw_ack}); end
      cyc(); smp();
      checks++; if ({drw_ack, drw_rdata, vga_rvalid} !== {1'b1, 16'hA534, 1'b0}) begin failures++; $display("FAIL sim_drw_data got=%b/%h/%b exp=1/a534/0", drw_ack, drw_rdata, vga_rvalid); end
   endtask

   task automatic test_wr_then_rd();
      preload(12'h0AB, 16'hC300);
      cyc(); drw_req = 1'b1; drw_we = 1'b1; drw_addr = 20'h000AB; drw_wdata = 16'h5AA5; drw_be = 2'b01; smp();
      checks++; if (drw_gnt !== 1'b1) begin failures++; $display("FAIL wtr_wgrant got=%b exp=1", drw_gnt); end
      cyc(); drw_req = 1'b0; vga_req = 1'b1; vga_addr = 20'h000AB; smp();
      checks++; if ({vga_gnt, SRAM_OE_N, SRAM_WE_N} !== 3'b010) begin failures++; $display("FAIL wtr_wr_a got=%b exp=010", {vga_gnt, SRAM_OE_N, SRAM_WE_N}); end
      cyc(); smp();
      checks++; if ({vga_gnt, SRAM_OE_N, SRAM_WE_N} !== 3'b111) begin failures++; $display("FAIL wtr_wr_b got=%b exp=111", {vga_gnt, SRAM_OE_N, SRAM_WE_N}); end
      cyc(); vga_req = 1'b0; smp();
      checks++; if ({drw_ack, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ} !== {4'b1001, 16'hC3A5}) begin failures++; $display("FAIL wtr_rd_a_bus got=%b/%h exp=1001/c3a5", {drw_ack, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, SRAM_DQ); end
      cyc(); smp();
      checks++; if ({SRAM_OE_N, SRAM_WE_N, SRAM_DQ} !== {2'b01, 16'hC3A5}) begin failures++; $display("FAIL wtr_rd_b_bus got=%b/%h exp=01/c3a5", {SRAM_OE_N, SRAM_WE_N}, SRAM_DQ); end
      cyc(); smp();
      checks++; if ({vga_rvalid, vga_rdata} !== {1'b1, 16'hC3A5}) begin failures++; $display("FAIL wtr_rdata got=%b/%h exp=1/c3a5", vga_rvalid, vga_rdata); end
   endtask

   task automatic test_reset_write();
      cyc(); drw_req = 1'b1; drw_we = 1'b1; drw_addr = 20'h00777; drw_wdata = 16'h0F0F; drw_be = 2'b11; smp();
      checks++; if (drw_gnt !== 1'b1) begin failures++; $display("FAIL rstw_grant got=%b exp=1", drw_gnt); end
      cyc(); drw_req = 1'b0; Reset = 1'b1; smp();
      checks++; if (SRAM_WE_N !== 1'b0) begin failures++; $display("FAIL rstw_in_wr_a got=%b exp=0", SRAM_WE_N); end
      cyc(); Reset = 1'b0; probe_en = 1'b1; smp();
      checks++; if ({SRAM_WE_N, SRAM_CE_N, drw_ack} !== 3'b110) begin failures++; $display("FAIL rstw_abort got=%b exp=110", {SRAM_WE_N, SRAM_CE_N, drw_ack}); end
      checks++; if (SRAM_DQ !== 16'h0000) begin failures++; $display("FAIL rstw_dq_released got=%h exp=0000", SRAM_DQ); end
      cyc(); probe_en = 1'b0; smp();
      checks++; if (drw_ack !== 1'b0) begin failures++; $display("FAIL rstw_no_ack1 got=%b exp=0", drw_ack); end
      cyc(); smp();
      checks++; if (drw_ack !== 1'b0) begin failures++; $display("FAIL rstw_no_ack2 got=%b exp=0", drw_ack); end
   endtask

   task automatic test_fairness();
      int  vcnt;
      bit  got;
      vcnt = 0;
      got  = 1'b0;
      cyc(); vga_req = 1'b1; vga_addr = 20'h00100;
      drw_req = 1'b1; drw_we = 1'b0; drw_addr = 20'h00345; drw_be = 2'b11;
      for (int i = 0; i < 40 && !got; i++) begin
         smp();
         if (drw_gnt) got = 1'b1;
         else begin
            if (vga_gnt) vcnt++;
            cyc();
         end
      end
      cyc(); vga_req = 1'b0; drw_req = 1'b0;
`ifdef SRAM_ARB_FAIR_EN
      checks++; if ({got, vcnt} !== {1'b1, 32'd4}) begin failures++; $display("FAIL fair_draw_after_4 got=%b/%0d exp=1/4", got, vcnt); end
`else
      checks++; if ({got, vcnt} !== {1'b0, 32'd20}) begin failures++; $display("FAIL strict_priority got=%b/%0d exp=0/20", got, vcnt); end
`endif
      for (int i = 0; i < 8; i++) cyc();
   endtask

   initial begin
      test_reset();
      test_vga_read();
      test_draw_write();
      test_be_zero();
      test_simultaneous();
      test_wr_then_rd();
      test_reset_write();
      test_fairness();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter FAIR_MAX, default 4: maximum consecutive VGA grants while drw_req is pending. It is used only when SRAM_ARB_FAIR_EN is defined.
REQ-002 SHALL have port Clk, input, 1: single system clock (SRAM_CLK domain); all logic on its rising edge.
REQ-003 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port vga_req, input, 1: scanout read request; held with vga_addr until granted.
REQ-005 SHALL have port vga_addr, input, 20: scanout word address.
REQ-006 SHALL have port vga_gnt, output, 1: combinational pulse in the cycle vga_req is accepted.
REQ-007 SHALL have ports vga_rdata (output, 16) and vga_rvalid (output, 1): read data, valid for one cycle.
REQ-008 SHALL have ports drw_req, drw_we, drw_addr[19:0], drw_wdata[15:0] and drw_be[1:0], all inputs: draw-port request, write flag, address, data, byte enables ([1]=upper).
REQ-009 SHALL have port drw_gnt, output, 1: combinational pulse in the accept cycle.
REQ-010 SHALL have ports drw_ack (output, 1) and drw_rdata (output, 16): completion pulse; rdata valid with ack on reads.
REQ-011 SHALL have the SRAM pin ports SRAM_DQ (inout, 16), SRAM_ADDR (output, 20), and SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N (outputs, 1, active-low).

Function
REQ-012 SHALL implement FSM states IDLE, RD_A, RD_B, WR_A, WR_B.
- Decision points: IDLE, RD_B and WR_B.
- Decision with no request -> IDLE.
REQ-013 At a decision point, SHALL accept a request as follows:
- Both requests asserted: VGA wins, except as in REQ-026.
- Accept cycle: assert the matching gnt and latch address, we, wdata and be.
REQ-014 Accepted request SHALL cause the next state:
- VGA, or draw with we=0 -> RD_A.
- Draw with we=1 -> WR_A.
REQ-015 In RD_A and RD_B, SHALL drive the following:
- SRAM_ADDR = latched address; CE_N=0, OE_N=0, WE_N=1.
- DQ released (high-Z).
- UB_N/LB_N = 0/0 for VGA, ~be for draw.
REQ-016 SHALL capture SRAM_DQ at the rising edge ending RD_B, then present it on the requester's rdata with rvalid/ack high in the following cycle (grant cycle N -> data/valid cycle N+3).
REQ-017 In WR_A, SHALL drive the following:
- Latched address; CE_N=0, WE_N=0, OE_N=1.
- UB_N/LB_N = ~be.
- DQ = wdata.
REQ-018 In WR_B, SHALL hold address, data and byte lanes with WE_N=1 (data hold), and pulse drw_ack in the cycle after WR_B (grant N -> ack N+3).
REQ-019 SHALL drive SRAM_DQ only in WR_A and WR_B; high-Z in all other states.
REQ-020 Back-to-back accesses SHALL sustain one access per 2 cycles with no idle cycle; WR_B followed by RD_A is legal because DQ is released on the same edge that asserts OE_N=0.
REQ-021 In IDLE, SHALL drive CE_N=OE_N=WE_N=UB_N=LB_N=1 and hold SRAM_ADDR at its last value.
REQ-022 drw_be=2'b00 with drw_req SHALL still be granted and complete with no byte lanes enabled (ack still issued).
REQ-023 vga_rdata/drw_rdata SHALL hold their last captured value between valid pulses.

Reset
REQ-024 Reset high at any clock edge SHALL do all of the following:
- State -> IDLE; all SRAM control outputs = 1; SRAM_ADDR=0; DQ high-Z.
- gnt/ack/rvalid=0; rdata=0; fairness counter=0.
REQ-025 Reset asserted mid-access SHALL abort it: no rvalid/ack issued, and the SRAM write contents are undefined for an interrupted WR_A.

Configuration
REQ-026 SHALL compile fairness with macro SRAM_ARB_FAIR_EN:
- Defined: a counter increments on each VGA grant while drw_req=1 and clears on any draw grant or drw_req=0; when it equals FAIR_MAX and both request, draw wins.
- Undefined: strict VGA priority; no counter logic.

Verification
REQ-027 SHALL verify VGA read: SRAM model holds 0xBEEF at 0x00100; vga_req with addr 0x00100 -> vga_gnt in cycle N, CE_N/OE_N=0 in N+1..N+2, vga_rvalid=1 with rdata 0xBEEF in N+3.
REQ-028 SHALL verify draw write: we=1, addr 0x12345, wdata 0xA55A, be=2'b10 -> WE_N=0 for exactly one cycle, UB_N=0, LB_N=1; model upper byte becomes 0xA5 with the lower byte unchanged; drw_ack at N+3.
REQ-029 SHALL verify simultaneous requests: vga_req and drw_req high together -> VGA granted first, draw granted at VGA's RD_B, two accesses in 4 cycles with no idle.
REQ-030 SHALL verify fairness: vga_req held high with drw_req high.
- With SRAM_ARB_FAIR_EN defined and FAIR_MAX=4: draw granted after exactly 4 VGA grants.
- Without the macro: draw is never granted.
REQ-031 SHALL verify reset during a write: Reset asserted in WR_A -> next cycle WE_N=1, CE_N=1, DQ high-Z, no drw_ack.
REQ-032 SHALL verify write followed by read: draw write then VGA read of the same address -> no cycle with DQ driven and OE_N=0; read returns the written data.
